// File: rtl/signed_sub_with_saturation_pipe_if.sv
// Handshake bundle for the saturating subtractor pipeline: input side
// (a/b with valid/ready), output side (diff/flags with valid/ready) and the
// sticky overflow status/clear pair.
interface signed_sub_with_saturation_pipe_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         sat_pos;
  logic         sat_neg;
  logic         ovf_sticky;
  logic         clr_sticky;

  // The pipeline itself
  modport slave (
    input  in_valid, a, b, out_ready, clr_sticky,
    output in_ready, out_valid, diff, sat_pos, sat_neg, ovf_sticky
  );

  // Whoever feeds operands and consumes results
  modport master (
    output in_valid, a, b, out_ready, clr_sticky,
    input  in_ready, out_valid, diff, sat_pos, sat_neg, ovf_sticky
  );
endinterface

// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage pipelined signed subtractor with saturation: diff = sat(a - b).
// Stage 1 captures the wrapped difference plus operand sign bits; stage 2
// detects overflow from those signs and clamps to max/min. Each stage holds
// its contents when the stage after it cannot accept, so nothing is lost or
// duplicated under back-pressure.
// Optional feature: define SAT_SUB_OVF_CNT_EN to add the ovf_cnt output, a
// saturating count of accepted saturated results (width CNT_W).
module signed_sub_with_saturation_pipe #(
  parameter int W = 4
`ifdef SAT_SUB_OVF_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  signed_sub_with_saturation_pipe_if.slave bus
`ifdef SAT_SUB_OVF_CNT_EN
  , output logic [CNT_W-1:0] ovf_cnt
`endif
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // Stage 1 registers
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_diff_q, s1_diff_d;
  logic         s1_a_sign_q, s1_a_sign_d;
  logic         s1_b_sign_q, s1_b_sign_d;

  // Stage 2 (output) registers
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] diff_q, diff_d;
  logic         sat_pos_q, sat_pos_d;
  logic         sat_neg_q, sat_neg_d;
  logic         ovf_sticky_q, ovf_sticky_d;

  // Handshake and overflow helpers
  logic s2_adv;
  logic in_ready;
  logic pos_ovf;
  logic neg_ovf;
  logic sat_fire;

  // Ready chain: output stage frees up when empty or consumed this cycle
  always_comb begin
    s2_adv   = !out_valid_q | bus.out_ready;
    in_ready = !s1_valid_q | s2_adv;
    sat_fire = out_valid_q & bus.out_ready & (sat_pos_q | sat_neg_q);
  end

  // Stage 1: capture the wrapped difference and operand signs when accepting
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_diff_d   = s1_diff_q;
    s1_a_sign_d = s1_a_sign_q;
    s1_b_sign_d = s1_b_sign_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_diff_d   = bus.a - bus.b;
        s1_a_sign_d = bus.a[W-1];
        s1_b_sign_d = bus.b[W-1];
      end
    end
  end

  // Overflow only when operand signs differ and the wrapped result has the wrong sign
  always_comb begin
    pos_ovf = !s1_a_sign_q &  s1_b_sign_q &  s1_diff_q[W-1];
    neg_ovf =  s1_a_sign_q & !s1_b_sign_q & !s1_diff_q[W-1];
  end

  // Stage 2: clamp and publish; results hold while the consumer stalls
  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    sat_pos_d   = sat_pos_q;
    sat_neg_d   = sat_neg_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d    = pos_ovf ? MAX_POS : (neg_ovf ? MIN_NEG : s1_diff_q);
        sat_pos_d = pos_ovf;
        sat_neg_d = neg_ovf;
      end
    end
  end

  // Sticky overflow: set by any accepted saturated result, clear wins
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (bus.clr_sticky) begin
      ovf_sticky_d = 1'b0;
    end else if (sat_fire) begin
      ovf_sticky_d = 1'b1;
    end
  end

  // Pipeline and status registers, flushed by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_diff_q    <= '0;
      s1_a_sign_q  <= 1'b0;
      s1_b_sign_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      diff_q       <= '0;
      sat_pos_q    <= 1'b0;
      sat_neg_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_diff_q    <= s1_diff_d;
      s1_a_sign_q  <= s1_a_sign_d;
      s1_b_sign_q  <= s1_b_sign_d;
      out_valid_q  <= out_valid_d;
      diff_q       <= diff_d;
      sat_pos_q    <= sat_pos_d;
      sat_neg_q    <= sat_neg_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.diff       = diff_q;
  assign bus.sat_pos    = sat_pos_q;
  assign bus.sat_neg    = sat_neg_q;
  assign bus.ovf_sticky = ovf_sticky_q;

`ifdef SAT_SUB_OVF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Event counter: counts accepted saturated results, sticks at all-ones
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (bus.clr_sticky) begin
      ovf_cnt_d = '0;
    end else if (sat_fire && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Self-checking bench for signed_sub_with_saturation_pipe (W=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// so every handshake seen at a sample point completes on the next rising edge.
// Expected results come from integer arithmetic clamped to [-8, 7].
// With SAT_SUB_OVF_CNT_EN defined the counter is built with CNT_W=2.
module tb_signed_sub_with_saturation_pipe;

  localparam int W = 4;
`ifdef SAT_SUB_OVF_CNT_EN
  localparam int CNT_W   = 2;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
  logic [CNT_W-1:0] ovf_cnt;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  signed_sub_with_saturation_pipe_if #(.W(W)) bus ();

`ifdef SAT_SUB_OVF_CNT_EN
  signed_sub_with_saturation_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_cnt(ovf_cnt)
  );
`else
  signed_sub_with_saturation_pipe #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {sat_pos, sat_neg, diff} for every accepted operand pair, in order
  logic [5:0] exp_q[$];
  logic       exp_sticky = 1'b0;
  int         exp_cnt    = 0;

  // Reference: exact integer difference, clamped to the 4-bit signed range
  function automatic logic [5:0] ref_sub(input logic [3:0] a, input logic [3:0] b);
    int r;
    r = int'($signed(a)) - int'($signed(b));
    if (r > 7)  return {2'b10, 4'h7};
    if (r < -8) return {2'b01, 4'h8};
    return {2'b00, r[3:0]};
  endfunction

  // Status model advance for the coming rising edge
  function automatic void model_edge(input logic clr, input logic acc_sat);
    if (clr) begin
      exp_sticky = 1'b0;
      exp_cnt    = 0;
    end else if (acc_sat) begin
      exp_sticky = 1'b1;
`ifdef SAT_SUB_OVF_CNT_EN
      if (exp_cnt < CNT_TOP) exp_cnt++;
`endif
    end
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sat_pos, bus.sat_neg, bus.ovf_sticky} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {bus.out_valid, bus.sat_pos, bus.sat_neg, bus.ovf_sticky});
    end
    n_checks++;
    if (bus.diff !== 4'h0) begin
      n_fail++; $display("[TB] FAIL reset_diff: got %h expected 0", bus.diff);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    exp_sticky = 1'b0; exp_cnt = 0; exp_q.delete();
  endtask

  // Single transactions with the two-edge latency checked explicitly
  task automatic test_directed();
    logic [3:0] ta [4] = '{4'd3, 4'd7, 4'h8, 4'h8};
    logic [3:0] tb [4] = '{4'd5, 4'hF, 4'd1, 4'h8};
    logic [5:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = ta[i]; bus.b = tb[i];
      bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
      #1;
      n_checks++;
      if (bus.ovf_sticky !== exp_sticky) begin
        n_fail++; $display("[TB] FAIL dir_sticky[%0d]: got %b expected %b", i, bus.ovf_sticky, exp_sticky);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL dir_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
      end
      e = ref_sub(ta[i], tb[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL dir_early_valid[%0d]: got %b expected 0", i, bus.out_valid);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.sat_pos, bus.sat_neg, bus.diff} !== {1'b1, e}) begin
        n_fail++;
        $display("[TB] FAIL dir_result[%0d]: got v=%b sp=%b sn=%b d=%h expected v=1 sp=%b sn=%b d=%h",
                 i, bus.out_valid, bus.sat_pos, bus.sat_neg, bus.diff, e[5], e[4], e[3:0]);
      end
      model_edge(1'b0, e[5] | e[4]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.ovf_sticky !== exp_sticky) begin
      n_fail++; $display("[TB] FAIL dir_sticky_end: got %b expected %b", bus.ovf_sticky, exp_sticky);
    end
  endtask

  // Six back-to-back pairs with a three-cycle output stall in the middle
  task automatic test_back_to_back();
    logic [3:0] ta [6] = '{4'd1, 4'd7, 4'h9, 4'd4, 4'hC, 4'd6};
    logic [3:0] tb [6] = '{4'd2, 4'hE, 4'd3, 4'd4, 4'd5, 4'hA};
    int sent = 0, received = 0, low_ready = 0;
    logic held = 1'b0;
    logic [5:0] held_val = '0;
    logic [5:0] e;
    logic acc_sat;
    for (int cyc = 0; cyc < 40 && received < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready  = !(cyc >= 3 && cyc <= 5);
      bus.clr_sticky = 1'b0;
      bus.in_valid   = (sent < 6);
      bus.a = (sent < 6) ? ta[sent] : 4'h0;
      bus.b = (sent < 6) ? tb[sent] : 4'h0;
      #1;
      acc_sat = 1'b0;
      n_checks++;
      if (bus.ovf_sticky !== exp_sticky) begin
        n_fail++; $display("[TB] FAIL b2b_sticky: got %b expected %b", bus.ovf_sticky, exp_sticky);
      end
      if (held) begin
        n_checks++;
        if ({bus.out_valid, bus.sat_pos, bus.sat_neg, bus.diff} !== {1'b1, held_val}) begin
          n_fail++;
          $display("[TB] FAIL b2b_hold: got v=%b %b%b %h expected v=1 %b",
                   bus.out_valid, bus.sat_pos, bus.sat_neg, bus.diff, held_val);
        end
      end
      if (!bus.in_ready) low_ready++;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_sub(bus.a, bus.b));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_extra: unexpected result d=%h", bus.diff);
        end else begin
          e = exp_q.pop_front();
          acc_sat = e[5] | e[4];
          if ({bus.sat_pos, bus.sat_neg, bus.diff} !== e) begin
            n_fail++;
            $display("[TB] FAIL b2b_result[%0d]: got %b%b %h expected %b%b %h",
                     received, bus.sat_pos, bus.sat_neg, bus.diff, e[5], e[4], e[3:0]);
          end
        end
        received++;
      end
      held     = bus.out_valid && !bus.out_ready;
      held_val = {bus.sat_pos, bus.sat_neg, bus.diff};
      model_edge(1'b0, acc_sat);
    end
    n_checks++;
    if (received != 6) begin
      n_fail++; $display("[TB] FAIL b2b_count: got %0d results expected 6", received);
    end
    n_checks++;
    if (low_ready != 3) begin
      n_fail++; $display("[TB] FAIL b2b_in_ready_low: got %0d cycles expected 3", low_ready);
    end
  endtask

  // Random traffic, random back-pressure and occasional clears
  task automatic test_random();
    logic held = 1'b0;
    logic [5:0] held_val = '0;
    logic [5:0] e;
    logic acc_sat;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc < 380) begin
        bus.in_valid   = ($urandom_range(0, 3) != 0);
        bus.out_ready  = ($urandom_range(0, 9) < 7);
        bus.clr_sticky = ($urandom_range(0, 19) == 0);
      end else begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
      end
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      #1;
      acc_sat = 1'b0;
      n_checks++;
      if (bus.ovf_sticky !== exp_sticky) begin
        n_fail++; $display("[TB] FAIL rnd_sticky@%0d: got %b expected %b", cyc, bus.ovf_sticky, exp_sticky);
      end
`ifdef SAT_SUB_OVF_CNT_EN
      n_checks++;
      if (int'(ovf_cnt) != exp_cnt) begin
        n_fail++; $display("[TB] FAIL rnd_cnt@%0d: got %0d expected %0d", cyc, ovf_cnt, exp_cnt);
      end
`endif
      if (held) begin
        n_checks++;
        if ({bus.out_valid, bus.sat_pos, bus.sat_neg, bus.diff} !== {1'b1, held_val}) begin
          n_fail++; $display("[TB] FAIL rnd_hold@%0d: got v=%b d=%h expected v=1 d=%h",
                             cyc, bus.out_valid, bus.diff, held_val[3:0]);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_sub(bus.a, bus.b));
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL rnd_extra@%0d: unexpected result d=%h", cyc, bus.diff);
        end else begin
          e = exp_q.pop_front();
          acc_sat = e[5] | e[4];
          if ({bus.sat_pos, bus.sat_neg, bus.diff} !== e) begin
            n_fail++; $display("[TB] FAIL rnd_result@%0d: got %b%b %h expected %b%b %h",
                               cyc, bus.sat_pos, bus.sat_neg, bus.diff, e[5], e[4], e[3:0]);
          end
        end
      end
      held     = bus.out_valid && !bus.out_ready;
      held_val = {bus.sat_pos, bus.sat_neg, bus.diff};
      model_edge(bus.clr_sticky, acc_sat);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL rnd_drain: %0d results never appeared expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Clear wins over a same-cycle saturated accept; then saturate the counter
  task automatic test_clear_priority();
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_sticky = 1'b1;
    @(negedge clk);
    bus.clr_sticky = 1'b0;
    bus.in_valid = 1'b1; bus.a = 4'd7; bus.b = 4'hF;
    exp_sticky = 1'b0; exp_cnt = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.clr_sticky = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sat_pos, bus.diff} !== {2'b11, 4'h7}) begin
      n_fail++; $display("[TB] FAIL clr_sat_result: got v=%b sp=%b d=%h expected v=1 sp=1 d=7",
                         bus.out_valid, bus.sat_pos, bus.diff);
    end
    @(negedge clk);
    bus.clr_sticky = 1'b0;
    #1;
    n_checks++;
    if (bus.ovf_sticky !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr_wins_sticky: got %b expected 0", bus.ovf_sticky);
    end
`ifdef SAT_SUB_OVF_CNT_EN
    n_checks++;
    if (ovf_cnt !== '0) begin
      n_fail++; $display("[TB] FAIL clr_wins_cnt: got %0d expected 0", ovf_cnt);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = (i % 2 == 0) ? 4'd7 : 4'h8;
      bus.b = (i % 2 == 0) ? 4'hF : 4'd1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.ovf_sticky !== 1'b1) begin
      n_fail++; $display("[TB] FAIL five_sat_sticky: got %b expected 1", bus.ovf_sticky);
    end
`ifdef SAT_SUB_OVF_CNT_EN
    n_checks++;
    if (int'(ovf_cnt) != 3) begin
      n_fail++; $display("[TB] FAIL five_sat_cnt: got %0d expected 3", ovf_cnt);
    end
`endif
    exp_sticky = 1'b1;
  endtask

  // Reset with both stages full must discard everything
  task automatic test_reset_midflight();
    @(negedge clk);
    bus.out_ready = 1'b0; bus.clr_sticky = 1'b0;
    bus.in_valid = 1'b1; bus.a = 4'd7; bus.b = 4'hF;
    @(negedge clk);
    bus.a = 4'd2; bus.b = 4'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sat_pos, bus.in_ready, bus.ovf_sticky} !== 4'b1101) begin
      n_fail++; $display("[TB] FAIL mid_full: got v/sp/rdy/st=%b expected 1101",
                         {bus.out_valid, bus.sat_pos, bus.in_ready, bus.ovf_sticky});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sat_pos, bus.sat_neg, bus.ovf_sticky, bus.diff} !== 8'h00) begin
      n_fail++; $display("[TB] FAIL mid_reset: got v/sp/sn/st=%b d=%h expected 0000 d=0",
                         {bus.out_valid, bus.sat_pos, bus.sat_neg, bus.ovf_sticky}, bus.diff);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    exp_sticky = 1'b0; exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL mid_stale[%0d]: got out_valid=%b expected 0", i, bus.out_valid);
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_clear_priority();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
